// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time, the period and the duty ratio of an
// asynchronous PWM input. A restoring divider computes the duty. A timeout
// flags a missing waveform.
module pwm_capture #(
  parameter int unsigned DUTY_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pwm_in,
  input  logic                  clr,
  output logic [DUTY_WIDTH-1:0] duty,
  output logic [CNT_WIDTH-1:0]  high_cnt,
  output logic [CNT_WIDTH-1:0]  period_cnt,
  output logic                  valid,
  output logic                  stuck,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned ITER_W = (DUTY_WIDTH > 1) ? $clog2(DUTY_WIDTH) : 1;
  localparam logic [ITER_W-1:0]    ITER_LAST = ITER_W'(DUTY_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    MEASURE   = 2'd1,
    STUCK     = 2'd2
  } state_t;

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } div_state_t;

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_sync_d;
  state_t                r_state;
  div_state_t            r_div_state;
  logic [CNT_WIDTH-1:0]  r_period_ctr;
  logic [CNT_WIDTH-1:0]  r_high_ctr;
  logic [CNT_WIDTH-1:0]  r_div_high;
  logic [CNT_WIDTH-1:0]  r_div_period;
  logic [CNT_WIDTH-1:0]  r_rem;
  logic [DUTY_WIDTH-1:0] r_quot;
  logic [ITER_W-1:0]     r_iter;
  logic [DUTY_WIDTH-1:0] r_duty;
  logic [CNT_WIDTH-1:0]  r_high_cnt;
  logic [CNT_WIDTH-1:0]  r_period_cnt;
  logic                  r_valid;
  logic                  r_stuck;
  logic                  r_overrun;

  logic                  w_rise;
  logic                  w_snap;
  logic                  w_ovr_evt;
  logic                  w_timeout;
  logic [CNT_WIDTH:0]    w_shift;
  logic [CNT_WIDTH:0]    w_diff;
  logic                  w_ge;
  logic [CNT_WIDTH-1:0]  w_rem_next;
  logic [DUTY_WIDTH-1:0] w_quot_next;

  // Edge detection on the synchronized level; only rising edges drive the FSM
  assign w_rise    = r_sync2 & ~r_sync_d;
  assign w_snap    = (r_state == MEASURE) && w_rise;
  assign w_ovr_evt = w_snap && (r_div_state == DIV);
  assign w_timeout = (r_state != STUCK) && !w_rise && (r_period_ctr == CNT_MAX);

  // One restoring step: the remainder stays below the divisor, so the shift cannot overflow
  assign w_shift     = {r_rem, 1'b0};
  assign w_diff      = w_shift - {1'b0, r_div_period};
  assign w_ge        = (w_shift >= {1'b0, r_div_period});
  assign w_rem_next  = CNT_WIDTH'(w_ge ? w_diff : w_shift);
  assign w_quot_next = (r_quot << 1) | DUTY_WIDTH'(w_ge);

  assign duty       = r_duty;
  assign high_cnt   = r_high_cnt;
  assign period_cnt = r_period_cnt;
  assign valid      = r_valid;
  assign stuck      = r_stuck;
  assign overrun    = r_overrun;
  assign busy       = (r_div_state == DIV);

  // Two-flop synchronizer plus the delayed copy used for edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= pwm_in;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  // Measurement FSM, divider and result registers; stuck entry overrides the divider
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= WAIT_EDGE;
      r_div_state  <= IDLE;
      r_period_ctr <= '0;
      r_high_ctr   <= '0;
      r_div_high   <= '0;
      r_div_period <= '0;
      r_rem        <= '0;
      r_quot       <= '0;
      r_iter       <= '0;
      r_duty       <= '0;
      r_high_cnt   <= '0;
      r_period_cnt <= '0;
      r_valid      <= 1'b0;
      r_stuck      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_overrun <= w_ovr_evt | (r_overrun & ~clr);

      case (r_div_state)
        IDLE: begin
          if (w_snap) begin
            r_div_state  <= DIV;
            r_div_high   <= r_high_ctr;
            r_div_period <= r_period_ctr;
            r_rem        <= r_high_ctr;
            r_quot       <= '0;
            r_iter       <= '0;
          end
        end
        DIV: begin
          r_rem  <= w_rem_next;
          r_quot <= w_quot_next;
          r_iter <= r_iter + ITER_W'(1);
          if (r_iter == ITER_LAST) begin
            r_div_state  <= IDLE;
            r_duty       <= w_quot_next;
            r_high_cnt   <= r_div_high;
            r_period_cnt <= r_div_period;
            r_valid      <= 1'b1;
          end
        end
        default: r_div_state <= IDLE;
      endcase

      case (r_state)
        WAIT_EDGE: begin
          if (w_rise) begin
            r_state      <= MEASURE;
            r_period_ctr <= CNT_ONE;
            r_high_ctr   <= CNT_ONE;
          end else begin
            r_period_ctr <= r_period_ctr + CNT_ONE;
          end
        end
        MEASURE: begin
          if (w_rise) begin
            r_period_ctr <= CNT_ONE;
            r_high_ctr   <= CNT_ONE;
          end else begin
            r_period_ctr <= r_period_ctr + CNT_ONE;
            r_high_ctr   <= r_high_ctr + CNT_WIDTH'(r_sync2);
          end
        end
        STUCK: begin
          if (w_rise) begin
            r_state      <= MEASURE;
            r_stuck      <= 1'b0;
            r_period_ctr <= CNT_ONE;
            r_high_ctr   <= CNT_ONE;
          end
        end
        default: r_state <= WAIT_EDGE;
      endcase

      if (w_timeout) begin
        r_state      <= STUCK;
        r_stuck      <= 1'b1;
        r_div_state  <= IDLE;
        r_period_ctr <= '0;
        r_high_ctr   <= '0;
        r_duty       <= r_sync2 ? '1 : '0;
        r_high_cnt   <= '0;
        r_period_cnt <= '0;
        r_valid      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed and random PWM waveforms against a timing-level
// reference model of edges, divider occupancy and timeout.
module tb_pwm_capture;

  localparam int unsigned DW   = 8;
  localparam int unsigned CW   = 12;
  localparam int          MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pwm_in = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] duty;
  logic [CW-1:0] high_cnt;
  logic [CW-1:0] period_cnt;
  logic          valid;
  logic          stuck;
  logic          overrun;
  logic          busy;

  pwm_capture #(.DUTY_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .clr(clr),
    .duty(duty), .high_cnt(high_cnt), .period_cnt(period_cnt),
    .valid(valid), .stuck(stuck), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int duty;
    int hi;
    int per;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  int  prev_t = -1;
  int  prev_h = 0;
  int  last_acc = -1000;
  bit  exp_ovr = 1'b0;
  bit  last_coll = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid pulse with the cycle it appeared in
  always @(posedge clk) begin
    #1;
    if (valid === 1'b1)
      obs_q.push_back('{cyc, int'(duty), int'(high_cnt), int'(period_cnt)});
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A rising edge driven now is acted on 3 clocks later; it closes the previous period
  task automatic rise_model(input int h);
    int t;
    int s;
    int p;
    t = cyc;
    s = t + 3;
    last_coll = 1'b0;
    if (prev_t >= 0) begin
      p = t - prev_t;
      if (s <= last_acc + int'(DW)) begin
        last_coll = 1'b1;
        exp_ovr   = 1'b1;
      end else begin
        exp_q.push_back('{s + int'(DW), (prev_h * (1 << DW)) / p, prev_h, p});
        last_acc = s;
      end
    end
    prev_t = t;
    prev_h = h;
  endtask

  task automatic model_restart();
    prev_t   = -1;
    last_acc = -1000;
  endtask

  task automatic pulse(input int h, input int l);
    rise_model(h);
    pwm_in = 1'b1;
    step(h);
    pwm_in = 1'b0;
    step(l);
  endtask

  // Timeout fires MAXC clocks after the last rising edge was acted on
  task automatic expect_stuck(input bit lvl);
    exp_q.push_back('{prev_t + 3 + MAXC, lvl ? ((1 << DW) - 1) : 0, 0, 0});
    model_restart();
  endtask

  task automatic check_results(input string tag);
    int target;
    int guard;
    int n;
    target = cyc;
    guard  = 0;
    if (exp_q.size() > 0) target = exp_q[exp_q.size()-1].cyc;
    while (cyc <= target && guard < 20000) begin
      step(1);
      guard++;
    end
    step(DW + 4);
    chk($sformatf("%s.count", tag), 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d].cycle", tag, i),  64'(obs_q[i].cyc),  64'(exp_q[i].cyc));
      chk($sformatf("%s[%0d].duty", tag, i),   64'(obs_q[i].duty), 64'(exp_q[i].duty));
      chk($sformatf("%s[%0d].high", tag, i),   64'(obs_q[i].hi),   64'(exp_q[i].hi));
      chk($sformatf("%s[%0d].period", tag, i), 64'(obs_q[i].per),  64'(exp_q[i].per));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    step(3);
    chk("rst.duty", 64'(duty), 64'd0);
    chk("rst.high", 64'(high_cnt), 64'd0);
    chk("rst.period", 64'(period_cnt), 64'd0);
    chk("rst.valid", 64'(valid), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.stuck", 64'(stuck), 64'd0);
    chk("rst.overrun", 64'(overrun), 64'd0);
    rst = 1'b1;
    step(2);

    // Steady 25 % waveform
    repeat (6) pulse(64, 192);
    check_results("p64");
    chk("p64.overrun", 64'(overrun), 64'd0);

    // Extreme duty values
    pulse(1, 255);
    pulse(255, 1);
    pulse(64, 192);
    check_results("ext");
    chk("ext.overrun", 64'(overrun), 64'd0);

    // Short random periods, some colliding with the divider
    repeat (16) pulse(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)));
    pulse(40, 60);
    check_results("rnd");
    chk("rnd.overrun", 64'(overrun), 64'(exp_ovr));
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    exp_ovr = 1'b0;
    chk("clr_quiet", 64'(overrun), 64'(exp_ovr));

    // Input stuck low, then recovery with 100-cycle periods
    pulse(30, MAXC + 50);
    expect_stuck(1'b0);
    check_results("stuck0");
    chk("stuck0.flag", 64'(stuck), 64'd1);
    chk("stuck0.duty", 64'(duty), 64'd0);
    chk("stuck0.period", 64'(period_cnt), 64'd0);
    pulse(30, 70);
    chk("unstuck.flag", 64'(stuck), 64'd0);
    pulse(30, 70);
    check_results("unstuck");

    // Input stuck high
    rise_model(0);
    pwm_in = 1'b1;
    step(MAXC + 50);
    expect_stuck(1'b1);
    check_results("stuck1");
    chk("stuck1.flag", 64'(stuck), 64'd1);
    chk("stuck1.duty", 64'(duty), 64'd255);
    chk("stuck1.high", 64'(high_cnt), 64'd0);
    pwm_in = 1'b0;
    step(20);
    pulse(10, 40);
    pulse(10, 40);
    check_results("after1");
    chk("after1.flag", 64'(stuck), 64'd0);

    // Period 5: overrun, then clr coinciding with a snapshot cycle
    pulse(2, 3);
    pulse(2, 3);
    chk("ovr.second", 64'(overrun), 64'(exp_ovr));
    chk("ovr.set", 64'(overrun), 64'd1);
    for (int k = 0; k < 2; k++) begin
      rise_model(2);
      pwm_in = 1'b1;
      step(2);
      pwm_in = 1'b0;
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      exp_ovr = last_coll;
      chk($sformatf("clr_snap%0d", k), 64'(overrun), 64'(exp_ovr));
      step(2);
    end
    pulse(50, 50);
    check_results("ovr");

    // Reset pulse while the divider is busy
    pulse(20, 30);
    pwm_in = 1'b1;
    step(5);
    chk("mid.busy", 64'(busy), 64'd1);
    rst = 1'b0;
    step(1);
    chk("mid.duty", 64'(duty), 64'd0);
    chk("mid.high", 64'(high_cnt), 64'd0);
    chk("mid.period", 64'(period_cnt), 64'd0);
    chk("mid.valid", 64'(valid), 64'd0);
    chk("mid.busy0", 64'(busy), 64'd0);
    chk("mid.overrun", 64'(overrun), 64'd0);
    rst = 1'b1;
    model_restart();
    exp_ovr = 1'b0;
    rise_model(20);
    step(20);
    pwm_in = 1'b0;
    step(30);
    pulse(20, 30);
    check_results("rst");
    chk("final.overrun", 64'(overrun), 64'(exp_ovr));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
